// File: rtl/pushbox_pkg.sv
// Shared types and constants for the push-box game display path.
package pushbox_pkg;

   typedef logic [3:0] bcd_t;

   localparam int          NDIG      = 4;
   localparam bcd_t        BCD_MAX   = 4'd9;
   localparam logic [3:0]  AN_IDLE   = 4'b1110;
   localparam logic [15:0] COUNT_MAX = 16'h9999;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: increments or decrements a single digit and reports
// carry/borrow to the next decade up.
module bcd_digit
   import pushbox_pkg::*;
(
   input  bcd_t d,
   input  logic up,
   input  logic down,
   output bcd_t d_next,
   output logic carry,
   output logic borrow
);

   always_comb begin
      d_next = d;
      if (up) begin
         d_next = (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
      end else if (down) begin
         d_next = (d == 4'd0) ? BCD_MAX : d - 4'd1;
      end
   end

   assign carry  = up & (d == BCD_MAX);
   assign borrow = down & (d == 4'd0);

endmodule

// File: rtl/step_counter_scan.sv
// Push-box move counter: 4-digit saturating BCD count with undo/clear,
// time-multiplexed onto one digit bus with active-low digit enables.
module step_counter_scan
   import pushbox_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        dec,
   input  logic        clr,
   output logic [15:0] count_bcd,
   output logic        ovf,
   output logic [3:0]  digit_val,
   output logic [3:0]  an_n
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic          inc_q, dec_q, clr_q;
   logic          rise_inc, rise_dec, rise_clr;
   logic          inc_only, dec_only;
   logic [15:0]   count_q, count_d, chain_next;
   logic          ovf_q, ovf_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d, idx_next;
   logic          tick;
   bcd_t          digit_val_q, digit_val_d;
   logic [3:0]    an_n_q, an_n_d;

   assign rise_inc = inc & ~inc_q;
   assign rise_dec = dec & ~dec_q;
   assign rise_clr = clr & ~clr_q;
   assign inc_only = rise_inc & ~rise_dec & ~rise_clr;
   assign dec_only = rise_dec & ~rise_inc & ~rise_clr;

   // Ripple chain: each decade takes its step request from the one below.
   for (genvar k = 0; k < NDIG; k++) begin : g_dig
      logic up, down, carry, borrow;
      bcd_t d_next;
      if (k == 0) begin : g_lsd
         assign up   = inc_only;
         assign down = dec_only;
      end else begin : g_upper
         assign up   = g_dig[k-1].carry;
         assign down = g_dig[k-1].borrow;
      end
      bcd_digit u_digit (
         .d      (count_q[4*k +: 4]),
         .up     (up),
         .down   (down),
         .d_next (d_next),
         .carry  (carry),
         .borrow (borrow)
      );
      assign chain_next[4*k +: 4] = d_next;
   end

   always_comb begin
      count_d = chain_next;
      ovf_d   = ovf_q;
      if (rise_clr) begin
         count_d = 16'h0000;
         ovf_d   = 1'b0;
      end else if (inc_only && count_q == COUNT_MAX) begin
         count_d = count_q;
         ovf_d   = 1'b1;
      end else if (dec_only && count_q == 16'h0000) begin
         count_d = count_q;
      end
   end

   // Enables and digit code load together from the upcoming slot so they
   // can never disagree about which digit is shown.
   always_comb begin
      tick        = (presc_q == PW'(SCAN_DIV - 1));
      idx_next    = idx_q + 2'd1;
      presc_d     = tick ? '0 : presc_q + PW'(1);
      idx_d       = idx_q;
      digit_val_d = digit_val_q;
      an_n_d      = an_n_q;
      if (tick) begin
         idx_d       = idx_next;
         digit_val_d = count_q[{idx_next, 2'b00} +: 4];
         an_n_d      = ~(4'b0001 << idx_next);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inc_q       <= 1'b0;
         dec_q       <= 1'b0;
         clr_q       <= 1'b0;
         count_q     <= 16'h0000;
         ovf_q       <= 1'b0;
         presc_q     <= '0;
         idx_q       <= 2'd0;
         digit_val_q <= 4'd0;
         an_n_q      <= AN_IDLE;
      end else begin
         inc_q       <= inc;
         dec_q       <= dec;
         clr_q       <= clr;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         presc_q     <= presc_d;
         idx_q       <= idx_d;
         digit_val_q <= digit_val_d;
         an_n_q      <= an_n_d;
      end
   end

   assign count_bcd = count_q;
   assign ovf       = ovf_q;
   assign digit_val = digit_val_q;
   assign an_n      = an_n_q;

endmodule
